bht_fb_arbiter: RTL and testbench
=================================

# bht_fb_arbiter

Collects branch-outcome feedback from the two commit slots and serialises it onto the predictor's single BHT update port (fb_ena / fb_pc / fb_taken_stat). Sits between the commit stage and the IFU predictor. Buffers feedback in a small FIFO while the predictor is not accepting updates, and delivers it in program order, at most one update per cycle.

## Interface
- FIFO_DEPTH, 8: feedback queue entries; power of two, ≥4.
- ADDR_W, 32: PC width; matches `ADDR_TP.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- upd_ena  in  1  predictor accepting updates; same signal as the predictor's pd_ena.
- req0_valid  in  1  commit slot 0 retires a conditional branch (older slot).
- req0_pc  in  ADDR_W  PC of slot 0 branch.
- req0_taken  in  1  resolved direction of slot 0.
- req1_valid / req1_pc / req1_taken  in  1 / ADDR_W / 1  same for slot 1 (younger).
- req_ready  out  1  ≥2 free entries; commit may assert either valid only when high.
- fb_ena  out  1  update strobe to predictor.
- fb_pc  out  ADDR_W  update PC.
- fb_taken_stat  out  1  update direction.
- occupancy  out  $clog2(FIFO_DEPTH)+1  entries held.
- ovf_err  out  1  sticky: a request was dropped.

## Operation
- Enqueue order per cycle: req0 before req1. If only req1_valid, it takes one slot.
- Dequeue: fb_ena = upd_ena && !empty; fb_pc / fb_taken_stat = head entry. The head is popped on every cycle where fb_ena is high.
- When upd_ena is low, nothing is dequeued. fb_ena is 0 and the queue holds its contents.
- Simultaneous push(es) and pop: occupancy_next = occupancy + pushes − pop. Pointers wrap modulo FIFO_DEPTH.
- req_ready = (FIFO_DEPTH − occupancy) ≥ 2. It is evaluated from registered occupancy, so it does not depend on same-cycle pops.
- Overflow: a valid request with no free slot is dropped and ovf_err sets.
  - A pop in the same cycle does not free a slot for that cycle's push.
  - ovf_err clears only on rst.
- When upd_ena is low, fb_pc / fb_taken_stat still show the head, but fb_ena gates them. When empty, they hold the last head value.
- Reset:
  - Pointers = 0, occupancy = 0, ovf_err = 0.
  - fb_ena = 0; fb_pc = 0 and fb_taken_stat = 0 are forced while empty after reset.
  - req_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all queued feedback; the predictor table is not touched.
- No state machine beyond FIFO pointers. Status: EMPTY (occupancy = 0), NORMAL, FULL (occupancy = FIFO_DEPTH).

## Timing
- Without bypass: a request sampled at edge N is visible on fb_* during cycle N+1 if the queue was empty and upd_ena = 1. The predictor writes the BHT at edge N+1.
- Throughput: one update per cycle with upd_ena high. Two pushes per cycle can therefore grow the queue.
- occupancy and req_ready update at the clock edge. fb_* are combinational from the head and upd_ena.

## Configuration
- BHT_FB_BYPASS_EN defined: when the queue is empty and upd_ena = 1, the oldest valid request drives fb_* combinationally in the same cycle (zero latency) and is not enqueued. Any younger request is enqueued normally. req_ready is unchanged.
- BHT_FB_BYPASS_EN undefined: every request goes through the FIFO, giving a fixed 1-cycle minimum latency.

## Structure
- Shared header utils.v supplies `ADDR_TP, `TRUE, `FALSE and `ZERO_WORD. No new shared typedefs; FIFO_DEPTH stays a local parameter.
- One sub-module: fb_fifo, a synchronous FIFO with two write ports and one read port, parameterised by depth and entry width ADDR_W+1 ({taken, pc}). The top level holds the ready/overflow logic and the bypass mux.

## Test plan
- Single push: req0 pc=0x100, taken=1, upd_ena=1, empty queue → fb_ena=1, fb_pc=0x100, fb_taken_stat=1 next cycle (same cycle with BHT_FB_BYPASS_EN); occupancy returns to 0.
- Dual push ordering: req0 pc=0x200 (taken=0) and req1 pc=0x204 (taken=1) together → 0x200 then 0x204 on consecutive cycles.
- Stall: upd_ena=0, push 4 entries → fb_ena=0, occupancy=4. Raise upd_ena → 4 consecutive updates in order, occupancy 4→0.
- Full/ready: upd_ena=0, fill to 7 → req_ready=0. Force req0+req1 valid → one entry stored (occupancy=8), one dropped, ovf_err=1.
- Wrap-around: 20 single pushes with upd_ena toggling every 3 cycles → all 20 PCs appear exactly once, in order.
- Reset mid-operation: occupancy=5, assert rst for one cycle → occupancy=0, fb_ena=0, ovf_err=0, req_ready=1. Old entries never appear.

Source files
------------

// File: rtl/bht_fb_arbiter_pkg.sv
// Shared types and defaults for the BHT feedback arbiter.
// Queue status is derived from occupancy alone; there is no other control state.
package bht_fb_arbiter_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ADDR_W     = 32;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_NORMAL,
    ST_FULL
  } fifo_status_e;

  function automatic fifo_status_e fifo_status(input int occ, input int depth);
    if (occ == 0)
      return ST_EMPTY;
    if (occ >= depth)
      return ST_FULL;
    return ST_NORMAL;
  endfunction

endpackage

// File: rtl/bht_fb_arbiter_fb_fifo.sv
// Synchronous FIFO with two write ports (A then B, in order) and one read port.
// Port B is only used together with port A; the head is read combinationally.
module fb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wa_en,
  input  logic [WIDTH-1:0]           wa_data,
  input  logic                       wb_en,
  input  logic [WIDTH-1:0]           wb_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [PTR_W-1:0] wr_ptr_b;
  logic [1:0]       push_cnt;

  // Power-of-two depth lets pointer arithmetic wrap naturally.
  assign wr_ptr_b  = wr_ptr_reg + PTR_W'(1);
  assign push_cnt  = {1'b0, wa_en} + {1'b0, wb_en};
  assign head_data = mem[rd_ptr_reg];
  assign occupancy = occ_reg;

  always_ff @(posedge clk) begin
    if (wa_en)
      mem[wr_ptr_reg] <= wa_data;
    if (wb_en)
      mem[wr_ptr_b] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_cnt);
      if (rd_en)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      occ_reg <= occ_reg + OCC_W'(push_cnt) - OCC_W'(rd_en);
    end
  end

endmodule

// File: rtl/bht_fb_arbiter.sv
// Serialises two-slot commit branch feedback onto the single BHT update port.
// Optional zero-latency bypass when empty: define BHT_FB_BYPASS_EN.
module bht_fb_arbiter
  import bht_fb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_ena,
  input  logic                          req0_valid,
  input  logic [ADDR_W-1:0]             req0_pc,
  input  logic                          req0_taken,
  input  logic                          req1_valid,
  input  logic [ADDR_W-1:0]             req1_pc,
  input  logic                          req1_taken,
  output logic                          req_ready,
  output logic                          fb_ena,
  output logic [ADDR_W-1:0]             fb_pc,
  output logic                          fb_taken_stat,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          ovf_err
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + 1;

  fifo_status_e     status;
  logic [OCC_W-1:0] free_slots;
  logic             empty;
  logic             bypass;
  logic [ENT_W-1:0] byp_data;
  logic [ENT_W-1:0] head_data;
  logic [ENT_W-1:0] fb_data;
  logic [ENT_W-1:0] last_reg;
  logic             ovf_err_reg;
  logic             pop;
  logic             a_valid;
  logic [ENT_W-1:0] a_data;
  logic             b_valid;
  logic [ENT_W-1:0] b_data;
  logic             wa_en;
  logic             wb_en;
  logic             drop;

  assign status     = fifo_status(int'(occupancy), FIFO_DEPTH);
  assign empty      = (status == ST_EMPTY);
  assign free_slots = OCC_W'(FIFO_DEPTH) - occupancy;
  assign req_ready  = (free_slots >= OCC_W'(2));
  assign byp_data   = req0_valid ? {req0_taken, req0_pc} : {req1_taken, req1_pc};

`ifdef BHT_FB_BYPASS_EN
  assign bypass = empty && upd_ena && (req0_valid || req1_valid);
`else
  assign bypass = 1'b0;
`endif

  // Compact valid requests into write ports A/B, oldest first; a bypassed
  // request is consumed directly and only the younger one is queued.
  always_comb begin
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    if (bypass) begin
      if (req0_valid && req1_valid) begin
        a_valid = 1'b1;
        a_data  = {req1_taken, req1_pc};
      end
    end else if (req0_valid) begin
      a_valid = 1'b1;
      a_data  = {req0_taken, req0_pc};
      b_valid = req1_valid;
      b_data  = {req1_taken, req1_pc};
    end else if (req1_valid) begin
      a_valid = 1'b1;
      a_data  = {req1_taken, req1_pc};
    end
  end

  // Free space comes from registered occupancy: a same-cycle pop never helps.
  assign wa_en = a_valid && (status != ST_FULL);
  assign wb_en = b_valid && (free_slots >= OCC_W'(2));
  assign drop  = (a_valid && !wa_en) || (b_valid && !wb_en);

  assign pop           = upd_ena && !empty;
  assign fb_ena        = bypass || pop;
  assign fb_data       = bypass ? byp_data : (empty ? last_reg : head_data);
  assign fb_pc         = fb_data[ADDR_W-1:0];
  assign fb_taken_stat = fb_data[ADDR_W];
  assign ovf_err       = ovf_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg    <= '0;
      ovf_err_reg <= 1'b0;
    end else begin
      if (fb_ena)
        last_reg <= fb_data;
      if (drop)
        ovf_err_reg <= 1'b1;
    end
  end

  fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fb_fifo (
    .clk       (clk),
    .rst       (rst),
    .wa_en     (wa_en),
    .wa_data   (a_data),
    .wb_en     (wb_en),
    .wb_data   (b_data),
    .rd_en     (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_bht_fb_arbiter.sv
// Self-checking bench for bht_fb_arbiter: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_bht_fb_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd_ena = 1'b0;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_pc = '0;
  logic          req0_taken = 1'b0;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_pc = '0;
  logic          req1_taken = 1'b0;
  logic          req_ready;
  logic          fb_ena;
  logic [AW-1:0] fb_pc;
  logic          fb_taken_stat;
  logic [OW-1:0] occupancy;
  logic          ovf_err;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {taken, pc}, last shown value, sticky overflow.
  logic [AW:0]   mq[$];
  logic [AW:0]   m_last = '0;
  logic          m_ovf = 1'b0;
  logic [AW-1:0] delivered[$];

  bht_fb_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_ena       (upd_ena),
    .req0_valid    (req0_valid),
    .req0_pc       (req0_pc),
    .req0_taken    (req0_taken),
    .req1_valid    (req1_valid),
    .req1_pc       (req1_pc),
    .req1_taken    (req1_taken),
    .req_ready     (req_ready),
    .fb_ena        (fb_ena),
    .fb_pc         (fb_pc),
    .fb_taken_stat (fb_taken_stat),
    .occupancy     (occupancy),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v0, input logic [AW-1:0] p0, input logic t0,
                       input logic v1, input logic [AW-1:0] p1, input logic t1,
                       input logic up);
    logic        byp;
    logic        exp_ena;
    logic [AW:0] exp_fb;
    logic [AW:0] incoming[$];
    int          free;
    req0_valid = v0; req0_pc = p0; req0_taken = t0;
    req1_valid = v1; req1_pc = p1; req1_taken = t1;
    upd_ena = up;
    @(negedge clk);
    byp = 1'b0;
`ifdef BHT_FB_BYPASS_EN
    byp = (mq.size() == 0) && up && (v0 || v1);
`endif
    if (byp) begin
      exp_ena = 1'b1;
      exp_fb  = v0 ? {t0, p0} : {t1, p1};
    end else begin
      exp_ena = up && (mq.size() > 0);
      exp_fb  = (mq.size() > 0) ? mq[0] : m_last;
    end
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("req_ready", 64'(req_ready), 64'((DEPTH - mq.size()) >= 2));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("fb_ena", 64'(fb_ena), 64'(exp_ena));
    chk("fb_pc", 64'(fb_pc), 64'(exp_fb[AW-1:0]));
    chk("fb_taken_stat", 64'(fb_taken_stat), 64'(exp_fb[AW]));
    if (fb_ena)
      delivered.push_back(fb_pc);
    @(posedge clk);
    #1;
    free = DEPTH - mq.size();
    if (v0) incoming.push_back({t0, p0});
    if (v1) incoming.push_back({t1, p1});
    if (byp)
      m_last = incoming.pop_front();
    else if (up && mq.size() > 0)
      m_last = mq.pop_front();
    foreach (incoming[i]) begin
      if (free > 0) begin
        mq.push_back(incoming[i]);
        free--;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic up);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, up);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    upd_ena = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_last = '0;
    m_ovf = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    logic up;
    logic rdy;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state, then single push 0x100.
    idle(1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Dual push ordering.
    delivered.delete();
    cycle(1'b1, 32'h200, 1'b0, 1'b1, 32'h204, 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    chk("dual_count", 64'(delivered.size()), 64'd2);
    if (delivered.size() == 2) begin
      chk("dual_first", 64'(delivered[0]), 64'h200);
      chk("dual_second", 64'(delivered[1]), 64'h204);
    end

    // Stall with four entries, then drain.
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 32'h304, 1'b1, 1'b0);
    cycle(1'b1, 32'h308, 1'b1, 1'b1, 32'h30c, 1'b0, 1'b0);
    idle(1'b0);
    repeat (5) idle(1'b1);

    // Fill to 7, then force a dual push: one stored, one dropped.
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 32'h400 + 32'(4 * i), 1'(i % 2), 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h500, 1'b1, 1'b1, 32'h504, 1'b0, 1'b0);
    idle(1'b0);
    repeat (9) idle(1'b1);

    // Reset mid-operation with five entries held.
    do_reset();
    cycle(1'b1, 32'h600, 1'b1, 1'b1, 32'h604, 1'b1, 1'b0);
    cycle(1'b1, 32'h608, 1'b0, 1'b1, 32'h60c, 1'b1, 1'b0);
    cycle(1'b1, 32'h610, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();
    delivered.delete();
    repeat (3) idle(1'b1);
    chk("reset_no_old", 64'(delivered.size()), 64'd0);

    // Wrap-around: 20 pushes, upd_ena toggling every 3 cycles.
    delivered.delete();
    n = 0;
    cyc = 0;
    while ((n < 20 || mq.size() > 0) && cyc < 400) begin
      up = ((cyc / 3) % 2) == 0;
      if (n < 20 && (DEPTH - mq.size()) >= 2) begin
        cycle(1'b1, 32'h1000 + 32'(4 * n), 1'(n % 2), 1'b0, '0, 1'b0, up);
        n++;
      end else begin
        idle(up);
      end
      cyc++;
    end
    chk("wrap_bound", 64'(cyc < 400), 64'd1);
    chk("wrap_count", 64'(delivered.size()), 64'd20);
    for (int i = 0; i < 20 && i < delivered.size(); i++)
      chk("wrap_order", 64'(delivered[i]), 64'(32'h1000 + 32'(4 * i)));

    // Random traffic respecting req_ready.
    for (int i = 0; i < 300; i++) begin
      rdy = (DEPTH - mq.size()) >= 2;
      cycle(rdy && ($urandom_range(0, 1) == 1), $urandom & ~32'h3, 1'($urandom_range(0, 1)),
            rdy && ($urandom_range(0, 1) == 1), $urandom & ~32'h3, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0);
    end
    repeat (10) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
